// File: rtl/msx_bus_initiator.sv
// MSX slot bus initiator: turns single transfer requests into Z80-style memory or
// I/O cycles with programmable setup/strobe/hold timing and WAIT_n extension.
module msx_bus_initiator #(
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned STROBE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES   = 1,
  parameter int unsigned WAIT_TIMEOUT  = 1024
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        REQ,
  input  logic        REQ_WR,
  input  logic        REQ_IO,
  input  logic [15:0] REQ_ADDR,
  input  logic [7:0]  REQ_DATA,
  output logic        ACK,
  output logic        ERR,
  output logic [7:0]  RDATA,
  output logic        BUSY,
  output logic [15:0] BUS_ADDR,
  output logic [7:0]  BUS_DIN,
  output logic        BUS_SLTSL_n,
  output logic        BUS_MERQ_n,
  output logic        BUS_IORQ_n,
  output logic        BUS_RD_n,
  output logic        BUS_WR_n,
  output logic        BUS_CS1_n,
  output logic        BUS_CS2_n,
  output logic        BUS_CS12_n,
  input  logic [7:0]  BUS_DOUT,
  input  logic        BUS_BUSDIR_n,
  input  logic        BUS_WAIT_n
);

  localparam int unsigned MAX_PHASE =
    (SETUP_CYCLES > STROBE_CYCLES) ?
      ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES) :
      ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES);
  localparam int unsigned CW = $clog2(MAX_PHASE + 1);
  localparam int unsigned WW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;

  // The setup phase spends its first cycle after acceptance driving the bus,
  // so the setup counter runs 0..SETUP_CYCLES.
  localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYCLES);
  localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST   = WW'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  logic [2:0]    state_r;
  logic [CW-1:0] phase_cnt_r;
  logic [WW-1:0] wait_cnt_r;
  logic          wr_r;
  logic          io_r;
  logic [15:0]   addr_r;
  logic [7:0]    data_r;
  logic          timeout_r;
  logic [7:0]    rdata_cap_r;

  logic          timeout_s;
  logic          strobe_end_s;
  logic          cs1_hit_s;
  logic          cs2_hit_s;
  logic          mem_rd_s;

  // Strobe exit conditions and page decode for the latched request.
  always_comb begin
    timeout_s    = 1'b0;
    strobe_end_s = 1'b0;
    if (!BUS_WAIT_n) begin
      timeout_s = (WAIT_TIMEOUT != 32'd0) && (wait_cnt_r == WAIT_LAST);
    end else begin
      strobe_end_s = (phase_cnt_r == STROBE_LAST);
    end
    mem_rd_s  = !wr_r && !io_r;
    cs1_hit_s = (addr_r[15:14] == 2'b01);
    cs2_hit_s = (addr_r[15:14] == 2'b10);
  end

  // Transfer sequencer; every output is a register updated on the transition.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_r     <= ST_IDLE;
      phase_cnt_r <= '0;
      wait_cnt_r  <= '0;
      wr_r        <= 1'b0;
      io_r        <= 1'b0;
      addr_r      <= 16'h0000;
      data_r      <= 8'h00;
      timeout_r   <= 1'b0;
      rdata_cap_r <= 8'h00;
      ACK         <= 1'b0;
      ERR         <= 1'b0;
      RDATA       <= 8'h00;
      BUSY        <= 1'b0;
      BUS_ADDR    <= 16'h0000;
      BUS_DIN     <= 8'h00;
      BUS_SLTSL_n <= 1'b1;
      BUS_MERQ_n  <= 1'b1;
      BUS_IORQ_n  <= 1'b1;
      BUS_RD_n    <= 1'b1;
      BUS_WR_n    <= 1'b1;
      BUS_CS1_n   <= 1'b1;
      BUS_CS2_n   <= 1'b1;
      BUS_CS12_n  <= 1'b1;
    end else begin
      ACK <= 1'b0;
      ERR <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (REQ) begin
            wr_r        <= REQ_WR;
            io_r        <= REQ_IO;
            addr_r      <= REQ_ADDR;
            data_r      <= REQ_DATA;
            timeout_r   <= 1'b0;
            phase_cnt_r <= '0;
            BUSY        <= 1'b1;
            state_r     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (phase_cnt_r == '0) begin
            BUS_ADDR    <= addr_r;
            BUS_DIN     <= wr_r ? data_r : 8'h00;
            BUS_MERQ_n  <= io_r;
            BUS_IORQ_n  <= !io_r;
            BUS_SLTSL_n <= io_r;
          end
          if (phase_cnt_r == SETUP_LAST) begin
            phase_cnt_r <= '0;
            wait_cnt_r  <= '0;
            BUS_RD_n    <= wr_r;
            BUS_WR_n    <= !wr_r;
            BUS_CS1_n   <= !(mem_rd_s && cs1_hit_s);
            BUS_CS2_n   <= !(mem_rd_s && cs2_hit_s);
            BUS_CS12_n  <= !(mem_rd_s && (cs1_hit_s || cs2_hit_s));
            state_r     <= ST_STROBE;
          end else begin
            phase_cnt_r <= phase_cnt_r + CW'(1);
          end
        end
        ST_STROBE: begin
          if (timeout_s || strobe_end_s) begin
            // A timed-out read never trusts the bus: report open-bus data.
            timeout_r   <= timeout_s;
            rdata_cap_r <= (strobe_end_s && !BUS_BUSDIR_n) ? BUS_DOUT : 8'hFF;
            phase_cnt_r <= '0;
            BUS_RD_n    <= 1'b1;
            BUS_WR_n    <= 1'b1;
            BUS_CS1_n   <= 1'b1;
            BUS_CS2_n   <= 1'b1;
            BUS_CS12_n  <= 1'b1;
            state_r     <= ST_HOLD;
          end else if (BUS_WAIT_n) begin
            phase_cnt_r <= phase_cnt_r + CW'(1);
          end else begin
            wait_cnt_r  <= wait_cnt_r + WW'(1);
          end
        end
        ST_HOLD: begin
          if (phase_cnt_r == HOLD_LAST) begin
            BUS_SLTSL_n <= 1'b1;
            BUS_MERQ_n  <= 1'b1;
            BUS_IORQ_n  <= 1'b1;
            ACK         <= 1'b1;
            ERR         <= timeout_r;
            if (!wr_r) begin
              RDATA <= rdata_cap_r;
            end
            state_r     <= ST_DONE;
          end else begin
            phase_cnt_r <= phase_cnt_r + CW'(1);
          end
        end
        ST_DONE: begin
          BUSY    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          BUSY        <= 1'b0;
          BUS_SLTSL_n <= 1'b1;
          BUS_MERQ_n  <= 1'b1;
          BUS_IORQ_n  <= 1'b1;
          BUS_RD_n    <= 1'b1;
          BUS_WR_n    <= 1'b1;
          BUS_CS1_n   <= 1'b1;
          BUS_CS2_n   <= 1'b1;
          BUS_CS12_n  <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msx_bus_initiator.sv
// Directed bench for msx_bus_initiator: per-transfer strobe/latency profiles
// compared against hand-computed values, plus reset and wait/timeout cases.
module tb_msx_bus_initiator;

  logic        CLK = 1'b0;
  logic        RESET_n;
  logic        REQ, REQ_WR, REQ_IO;
  logic [15:0] REQ_ADDR;
  logic [7:0]  REQ_DATA;
  logic        ACK, ERR, BUSY;
  logic [7:0]  RDATA;
  logic [15:0] BUS_ADDR;
  logic [7:0]  BUS_DIN;
  logic        BUS_SLTSL_n, BUS_MERQ_n, BUS_IORQ_n, BUS_RD_n, BUS_WR_n;
  logic        BUS_CS1_n, BUS_CS2_n, BUS_CS12_n;
  logic [7:0]  BUS_DOUT;
  logic        BUS_BUSDIR_n, BUS_WAIT_n;

  int n_cmp = 0;
  int n_bad = 0;

  int cnt_sltsl, cnt_merq, cnt_iorq, cnt_rd, cnt_wr, cnt_cs1, cnt_cs2, cnt_cs12;
  int ack_cyc;
  logic        busy0, busy_after, ack_after, err_seen, saw_ack;
  logic [7:0]  rdata_seen, din_seen;
  logic [15:0] addr_seen;

  msx_bus_initiator #(.WAIT_TIMEOUT(16)) dut (
    .CLK(CLK), .RESET_n(RESET_n), .REQ(REQ), .REQ_WR(REQ_WR), .REQ_IO(REQ_IO),
    .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA), .ACK(ACK), .ERR(ERR), .RDATA(RDATA),
    .BUSY(BUSY), .BUS_ADDR(BUS_ADDR), .BUS_DIN(BUS_DIN), .BUS_SLTSL_n(BUS_SLTSL_n),
    .BUS_MERQ_n(BUS_MERQ_n), .BUS_IORQ_n(BUS_IORQ_n), .BUS_RD_n(BUS_RD_n),
    .BUS_WR_n(BUS_WR_n), .BUS_CS1_n(BUS_CS1_n), .BUS_CS2_n(BUS_CS2_n),
    .BUS_CS12_n(BUS_CS12_n), .BUS_DOUT(BUS_DOUT), .BUS_BUSDIR_n(BUS_BUSDIR_n),
    .BUS_WAIT_n(BUS_WAIT_n)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transfer; cycle k is the negedge after the k-th rising edge past acceptance.
  task automatic xfer(input logic wr, input logic io, input logic [15:0] addr,
                      input logic [7:0] data, input logic busdir_n, input logic [7:0] dout,
                      input int ws, input int wl);
    cnt_sltsl = 0; cnt_merq = 0; cnt_iorq = 0; cnt_rd = 0; cnt_wr = 0;
    cnt_cs1 = 0; cnt_cs2 = 0; cnt_cs12 = 0; ack_cyc = -1;
    err_seen = 1'bx; rdata_seen = 8'hxx; din_seen = 8'hxx; addr_seen = 16'hxxxx;
    REQ_WR = wr; REQ_IO = io; REQ_ADDR = addr; REQ_DATA = data; REQ = 1'b1;
    BUS_BUSDIR_n = busdir_n; BUS_DOUT = dout; BUS_WAIT_n = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    busy0 = BUSY;
    REQ = 1'b0; REQ_ADDR = ~addr; REQ_DATA = ~data; REQ_IO = ~io;
    for (int k = 0; k < 60 && ack_cyc < 0; k++) begin
      if (k > 0) @(negedge CLK);
      if (!BUS_SLTSL_n) cnt_sltsl++;
      if (!BUS_MERQ_n)  cnt_merq++;
      if (!BUS_IORQ_n)  cnt_iorq++;
      if (!BUS_RD_n)    cnt_rd++;
      if (!BUS_WR_n)    cnt_wr++;
      if (!BUS_CS1_n)   cnt_cs1++;
      if (!BUS_CS2_n)   cnt_cs2++;
      if (!BUS_CS12_n)  cnt_cs12++;
      if (!BUS_RD_n || !BUS_WR_n) begin
        addr_seen = BUS_ADDR;
        din_seen  = BUS_DIN;
      end
      if (ACK) begin
        ack_cyc    = k;
        err_seen   = ERR;
        rdata_seen = RDATA;
      end
      BUS_WAIT_n = !(k >= ws && k < ws + wl);
    end
    BUS_WAIT_n = 1'b1;
    BUS_BUSDIR_n = 1'b1;
    @(negedge CLK);
    busy_after = BUSY;
    ack_after  = ACK;
  endtask

  initial begin
    RESET_n = 1'b0; REQ = 1'b0; REQ_WR = 1'b0; REQ_IO = 1'b0;
    REQ_ADDR = 16'h0000; REQ_DATA = 8'h00;
    BUS_DOUT = 8'h00; BUS_BUSDIR_n = 1'b1; BUS_WAIT_n = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_strobes", {BUS_SLTSL_n, BUS_MERQ_n, BUS_IORQ_n, BUS_RD_n, BUS_WR_n,
                        BUS_CS1_n, BUS_CS2_n, BUS_CS12_n}, 8'hFF);
    chk("rst_addr_din", {BUS_ADDR, BUS_DIN}, 24'h000000);
    chk("rst_ack_err_busy_rdata", {ACK, ERR, BUSY, RDATA}, 11'h000);
    RESET_n = 1'b1;
    @(negedge CLK);

    // Memory write 7FFFh = 5Ah
    xfer(1'b1, 1'b0, 16'h7FFF, 8'h5A, 1'b1, 8'h00, 0, 0);
    chk("w_busy0", busy0, 1'b1);
    chk("w_sltsl_cyc", cnt_sltsl, 7);
    chk("w_merq_cyc", cnt_merq, 7);
    chk("w_iorq_cyc", cnt_iorq, 0);
    chk("w_wr_cyc", cnt_wr, 4);
    chk("w_rd_cyc", cnt_rd, 0);
    chk("w_cs_cyc", cnt_cs1 + cnt_cs2 + cnt_cs12, 0);
    chk("w_din", din_seen, 8'h5A);
    chk("w_addr", addr_seen, 16'h7FFF);
    chk("w_ack_cyc", ack_cyc, 8);
    chk("w_err", err_seen, 1'b0);
    chk("w_busy_ack_after", {busy_after, ack_after}, 2'b00);

    // Memory read 4000h from a driving responder
    xfer(1'b0, 1'b0, 16'h4000, 8'h00, 1'b0, 8'hC3, 0, 0);
    chk("r_rd_cyc", cnt_rd, 4);
    chk("r_cs1_cyc", cnt_cs1, 4);
    chk("r_cs12_cyc", cnt_cs12, 4);
    chk("r_cs2_cyc", cnt_cs2, 0);
    chk("r_rdata", rdata_seen, 8'hC3);
    chk("r_ack_cyc", ack_cyc, 8);

    // I/O read port 98h, nobody answers
    xfer(1'b0, 1'b1, 16'h0098, 8'h00, 1'b1, 8'h00, 0, 0);
    chk("io_iorq_cyc", cnt_iorq, 7);
    chk("io_merq_sltsl_cyc", cnt_merq + cnt_sltsl, 0);
    chk("io_cs_cyc", cnt_cs1 + cnt_cs2 + cnt_cs12, 0);
    chk("io_addr", addr_seen, 16'h0098);
    chk("io_rdata", rdata_seen, 8'hFF);
    chk("io_err", err_seen, 1'b0);

    // WAIT_n low for 10 sampled cycles during the strobe
    xfer(1'b0, 1'b0, 16'h8123, 8'h00, 1'b0, 8'h3C, 3, 10);
    chk("wt_rd_cyc", cnt_rd, 14);
    chk("wt_cs2_cyc", cnt_cs2, 14);
    chk("wt_cs1_cyc", cnt_cs1, 0);
    chk("wt_ack_cyc", ack_cyc, 18);
    chk("wt_rdata", rdata_seen, 8'h3C);
    chk("wt_err", err_seen, 1'b0);

    // WAIT_n stuck low: abort after 16 wait cycles
    xfer(1'b0, 1'b0, 16'hA000, 8'h00, 1'b0, 8'h42, 3, 100);
    chk("to_rd_cyc", cnt_rd, 16);
    chk("to_ack_cyc", ack_cyc, 20);
    chk("to_err", err_seen, 1'b1);
    chk("to_rdata", rdata_seen, 8'hFF);
    xfer(1'b0, 1'b0, 16'h5000, 8'h00, 1'b0, 8'h11, 0, 0);
    chk("after_to_ack_cyc", ack_cyc, 8);
    chk("after_to_err", err_seen, 1'b0);
    chk("after_to_rdata", rdata_seen, 8'h11);

    // Reset asserted in the middle of the strobe
    REQ_WR = 1'b0; REQ_IO = 1'b0; REQ_ADDR = 16'h6000; REQ = 1'b1;
    BUS_BUSDIR_n = 1'b0; BUS_DOUT = 8'h77;
    @(posedge CLK);
    @(negedge CLK);
    REQ = 1'b0;
    repeat (4) @(negedge CLK);
    chk("rst_mid_rd_active", BUS_RD_n, 1'b0);
    #2 RESET_n = 1'b0;
    #1 chk("rst_mid_async", {BUS_SLTSL_n, BUS_MERQ_n, BUS_IORQ_n, BUS_RD_n, BUS_WR_n,
                             BUS_CS1_n, BUS_CS2_n, BUS_CS12_n}, 8'hFF);
    saw_ack = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      if (ACK) saw_ack = 1'b1;
    end
    RESET_n = 1'b1;
    BUS_BUSDIR_n = 1'b1;
    repeat (12) begin
      @(negedge CLK);
      if (ACK) saw_ack = 1'b1;
    end
    chk("rst_mid_no_ack", saw_ack, 1'b0);
    chk("rst_mid_busy", BUSY, 1'b0);
    xfer(1'b1, 1'b0, 16'h1234, 8'hA5, 1'b1, 8'h00, 0, 0);
    chk("post_rst_wr_cyc", cnt_wr, 4);
    chk("post_rst_merq_cyc", cnt_merq, 7);
    chk("post_rst_din", din_seen, 8'hA5);
    chk("post_rst_ack_cyc", ack_cyc, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
